hex_display_scanner: RTL
========================

Name: hex_display_scanner

Overview:
- Downstream consumer of the ALU result bus (rout) driven by the register-file test FSM.
- Captures a 16-bit value and time-multiplexes it as four hex digits onto a common-anode 4-digit seven-segment display.
- Provides tear-free updates: new values take effect only at frame boundaries.
- Optional leading-zero blanking; emits a per-frame strobe for the test FSM.

Parameters:
PRESCALE, 50000, clk cycles per digit slot (>=1); sim benches use 4
BLANK_LEADING, 1, 1 = blank leading zero digits above digit 0; 0 = always show all four digits

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
value  input  16  data to display (ALU rout bus)
load  input  1  1 = capture value into pending register this cycle
cath  output  [1:7]  segment cathodes, active-low; cath[1]=a ... cath[7]=g
an  output  4  digit anodes, active-low; an[0] = least significant digit
digit_sel  output  2  index of the digit currently driven
frame_done  output  1  one-cycle pulse at each 3->0 digit wrap

Behaviour:
- One clock; reset is synchronous and active-high, sampled on posedge clk. Ports are named clk and reset.
- Reset (any cycle, including mid-frame):
  - prescale counter = 0, digit = 0, pending = 0, shadow = 0.
  - Outputs: an = 4'b1111, cath = 7'b1111111, digit_sel = 0, frame_done = 0.
- Prescaler:
  - cnt counts 0..PRESCALE-1 and wraps to 0.
  - tick is asserted while cnt == PRESCALE-1; with PRESCALE=1, tick is asserted every cycle.
- Digit counter: advances 0->1->2->3->0 on tick; holds otherwise.
- Pending register: pending <= value on every cycle with load=1. Multiple loads within a frame: the last one wins.
- Shadow register:
  - Updated only on the tick where digit wraps 3->0.
  - shadow <= (load ? value : pending), i.e. a load coincident with the wrap is bypassed directly into shadow.
- frame_done: registered; high for exactly the one cycle following the wrap tick, aligned with the first cycle digit_sel = 0 of the new frame.
- Outputs are registered from digit and shadow: an, cath and digit_sel change exactly 1 cycle after the digit register changes.
  - an: only bit [digit] is low.
  - cath: encodes shadow nibble [4*digit+3 : 4*digit].
- Segment codes (cath[1:7], active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Blanking (BLANK_LEADING=1):
  - Digit k (k = 1..3) is blanked when all shadow nibbles at positions >= k are zero.
  - Blanked digit: cath = 7'b1111111; its an bit is still driven low for timing uniformity.
  - Digit 0 is never blanked, so value 0 displays a single "0".
- First frame after reset shows shadow = 0: digit 0 shows "0"; digits 1-3 are blank when BLANK_LEADING=1.

Test Plan:
1. Reset, PRESCALE=4, load=1 value=16'h1234 for 1 cycle, run 2 frames -> second frame: an cycles 1110,1101,1011,0111 every 4 clks; cath = 1001100, 0000110, 0010010, 1001111; frame_done pulses once per 16 clks.
2. Tear-free update: value 16'h00FF loaded mid-frame while 16'h1234 is shown -> remaining digits of the current frame still show 1234 nibbles; next frame shows F, F, blank, blank (BLANK_LEADING=1).
3. load=1 value=16'hABCD on the exact wrap tick -> the immediately following frame shows D, C, b, A with no extra frame of delay.
4. value=16'h0000 and value=16'h0100 -> 0000 shows "0" on digit 0 with digits 1-3 blank; 0100 shows 0, 0, 1 on digits 0-2 with digit 3 blank.
5. Assert reset during digit 2 of a frame displaying 16'hFFFF -> next cycle an=1111, cath=1111111, frame_done=0; scanning restarts at digit 0 showing "0".
6. PRESCALE=1 -> digit advances every clk; frame_done pulses every 4 clks; an/cath lag digit_sel changes by exactly 1 cycle.

Source files
------------

// File: rtl/hex_display_scanner_if.sv
// Bus between the ALU result source (master) and the hex display scanner (slave).
// Carries the value/load capture pair and the multiplexed display outputs.
interface hex_display_scanner_if;
    logic [15:0] value;
    logic        load;
    logic [1:7]  cath;
    logic [3:0]  an;
    logic [1:0]  digit_sel;
    logic        frame_done;

    modport master (
        output value,
        output load,
        input  cath,
        input  an,
        input  digit_sel,
        input  frame_done
    );

    modport slave (
        input  value,
        input  load,
        output cath,
        output an,
        output digit_sel,
        output frame_done
    );
endinterface

// File: rtl/hex_display_scanner.sv
// Four-digit common-anode seven-segment scanner for a 16-bit value.
// Values are captured into a pending register and copied to the displayed
// shadow register only at the 3->0 digit wrap, so a frame never mixes values.
module hex_display_scanner #(
    parameter int PRESCALE      = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    hex_display_scanner_if.slave bus
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       digit_reg;
    logic [15:0]      pending_reg;
    logic [15:0]      shadow_reg;
    logic             wrap_reg;

    logic [3:0]       an_reg;
    logic [1:7]       cath_reg;
    logic [1:0]       digit_sel_reg;
    logic             frame_done_reg;

    logic             tick;
    logic             wrap;
    logic [3:0]       nibble;
    logic [1:7]       seg_code;
    logic [3:0]       blank_vec;

    assign tick = (cnt_reg == CNT_LAST);
    assign wrap = tick && (digit_reg == 2'd3);

    // Digit k is blank when every nibble from k upward is zero; digit 0 always shows.
    assign blank_vec[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_blank
            assign blank_vec[gi] = BLANK_LEADING && (shadow_reg[15:4*gi] == '0);
        end
    endgenerate

    assign nibble = shadow_reg[4*digit_reg +: 4];

    // Hex nibble to active-low segment pattern, cath[1]=a ... cath[7]=g.
    always_comb begin
        seg_code = 7'b1111111;
        case (nibble)
            4'h0: seg_code = 7'b0000001;
            4'h1: seg_code = 7'b1001111;
            4'h2: seg_code = 7'b0010010;
            4'h3: seg_code = 7'b0000110;
            4'h4: seg_code = 7'b1001100;
            4'h5: seg_code = 7'b0100100;
            4'h6: seg_code = 7'b0100000;
            4'h7: seg_code = 7'b0001111;
            4'h8: seg_code = 7'b0000000;
            4'h9: seg_code = 7'b0000100;
            4'hA: seg_code = 7'b0001000;
            4'hB: seg_code = 7'b1100000;
            4'hC: seg_code = 7'b0110001;
            4'hD: seg_code = 7'b1000010;
            4'hE: seg_code = 7'b0110000;
            4'hF: seg_code = 7'b0111000;
            default: seg_code = 7'b1111111;
        endcase
    end

    // Prescaler, digit counter, pending capture and frame-boundary shadow update.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg     <= '0;
            digit_reg   <= 2'd0;
            pending_reg <= 16'h0000;
            shadow_reg  <= 16'h0000;
            wrap_reg    <= 1'b0;
        end else begin
            cnt_reg  <= tick ? '0 : cnt_reg + 1'b1;
            wrap_reg <= wrap;
            if (tick) begin
                digit_reg <= digit_reg + 2'd1;
            end
            if (bus.load) begin
                pending_reg <= bus.value;
            end
            // A load landing on the wrap tick goes straight to the new frame.
            if (wrap) begin
                shadow_reg <= bus.load ? bus.value : pending_reg;
            end
        end
    end

    // Registered display outputs, one cycle behind the digit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_reg         <= 4'b1111;
            cath_reg       <= 7'b1111111;
            digit_sel_reg  <= 2'd0;
            frame_done_reg <= 1'b0;
        end else begin
            an_reg         <= ~(4'b0001 << digit_reg);
            cath_reg       <= blank_vec[digit_reg] ? 7'b1111111 : seg_code;
            digit_sel_reg  <= digit_reg;
            frame_done_reg <= wrap_reg;
        end
    end

    assign bus.an         = an_reg;
    assign bus.cath       = cath_reg;
    assign bus.digit_sel  = digit_sel_reg;
    assign bus.frame_done = frame_done_reg;

endmodule
